// File: rtl/round_scheduler.sv
// -----------------------------------------------------------------------------
// round_scheduler
//
// Game-flow controller for the Not-Not reaction game. A free-running 8-bit
// LFSR picks each round's instruction (UP/DOWN/LEFT/RIGHT/VOWEL/DIGIT,
// optionally negated). The block then times the player's response, judges the
// classified keypress, keeps lives and score, and shortens the response
// window after every correct answer.
//
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-high; all state to reset values
//   start           in   one-cycle pulse; starts a game from IDLE/GAME_OVER
//   key_valid       in   one-cycle pulse; key_class is valid this cycle
//   key_class[2:0]  in   0 UP,1 DOWN,2 LEFT,3 RIGHT,4 VOWEL,5 DIGIT,6/7 OTHER
//   instr[2:0]      out  current instruction code (0..5)
//   instr_not       out  1 = negated instruction
//   instr_valid     out  high while waiting for the player's response
//   verdict_valid   out  one-cycle pulse when a round is judged
//   verdict_correct out  verdict of the last round, held until the next one
//   timeout         out  last wrong verdict was a timeout, held until next
//   lives[1:0]      out  remaining lives
//   score[7:0]      out  correct answers this game, saturating at 255
//   game_over       out  high in GAME_OVER
// -----------------------------------------------------------------------------
module round_scheduler #(
    parameter int LIVES           = 3,
    parameter int ROUND_CYCLES    = 150000000,
    parameter int MIN_CYCLES      = 50000000,
    parameter int STEP_CYCLES     = 5000000,
    parameter int FEEDBACK_CYCLES = 25000000,
    parameter int CW              = 28
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    input  logic [2:0] key_class,
    output logic [2:0] instr,
    output logic       instr_not,
    output logic       instr_valid,
    output logic       verdict_valid,
    output logic       verdict_correct,
    output logic       timeout,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic       game_over
);

    localparam logic [CW-1:0] C_ROUND          = CW'(ROUND_CYCLES);
    localparam logic [CW-1:0] C_MIN            = CW'(MIN_CYCLES);
    localparam logic [CW-1:0] C_STEP           = CW'(STEP_CYCLES);
    localparam logic [CW-1:0] C_MIN_PLUS_STEP  = CW'(MIN_CYCLES + STEP_CYCLES);
    localparam logic [CW-1:0] C_FEEDBACK_LOAD  = CW'(FEEDBACK_CYCLES - 1);
    localparam logic [CW-1:0] C_ONE            = CW'(1);
    localparam logic [1:0]    C_LIVES          = 2'(LIVES);
    localparam logic [7:0]    C_LFSR_SEED      = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_KEY,
        S_CORRECT,
        S_WRONG,
        S_GAME_OVER
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [7:0]    r_lfsr;
    logic [CW-1:0] r_timer;
    logic [CW-1:0] r_window;
    logic [2:0]    r_instr;
    logic          r_instr_not;
    logic          r_verdict_valid;
    logic          r_verdict_correct;
    logic          r_timeout;
    logic [1:0]    r_lives;
    logic [7:0]    r_score;

    logic          w_lfsr_fb;
    logic          w_timer_zero;
    logic          w_start_game;
    logic          w_key_hit;
    logic          w_expire;
    logic          w_key_correct;
    logic [2:0]    w_issue_code;
    logic [CW-1:0] w_window_dec;
    logic [7:0]    w_score_inc;
    logic [1:0]    w_lives_dec;

    // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
    assign w_lfsr_fb    = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    assign w_timer_zero = (r_timer == '0);
    assign w_start_game = start && ((r_state == S_IDLE) || (r_state == S_GAME_OVER));
    assign w_key_hit    = (r_state == S_WAIT_KEY) && key_valid;
    // A keypress on the expiry cycle takes priority over the timeout
    assign w_expire     = (r_state == S_WAIT_KEY) && !key_valid && w_timer_zero;

    // Codes 6/7 never equal an instruction (0..5), so OTHER is only ever
    // right under a negated instruction.
    assign w_key_correct = r_instr_not ? (key_class != r_instr) : (key_class == r_instr);

    // Fold the two unused LFSR codes back onto 0/1
    assign w_issue_code = (r_lfsr[2:0] >= 3'd6) ? (r_lfsr[2:0] - 3'd6) : r_lfsr[2:0];

    // Compare before subtracting so the window cannot wrap below the floor
    assign w_window_dec = (r_window >= C_MIN_PLUS_STEP) ? (r_window - C_STEP) : C_MIN;
    assign w_score_inc  = (r_score != 8'hFF) ? (r_score + 8'd1) : r_score;
    assign w_lives_dec  = (r_lives != 2'd0) ? (r_lives - 2'd1) : r_lives;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_GAME_OVER: begin
                if (start) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT_KEY;
            end
            S_WAIT_KEY: begin
                if (key_valid) begin
                    w_state_next = w_key_correct ? S_CORRECT : S_WRONG;
                end else if (w_timer_zero) begin
                    w_state_next = S_WRONG;
                end
            end
            S_CORRECT: begin
                if (w_timer_zero) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_WRONG: begin
                // r_lives has already been decremented on entry
                if (w_timer_zero) begin
                    w_state_next = (r_lives != 2'd0) ? S_ISSUE : S_GAME_OVER;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: LFSR, timer, instruction, verdict, lives, score, window
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr            <= C_LFSR_SEED;
            r_timer           <= '0;
            r_window          <= C_ROUND;
            r_instr           <= 3'd0;
            r_instr_not       <= 1'b0;
            r_verdict_valid   <= 1'b0;
            r_verdict_correct <= 1'b0;
            r_timeout         <= 1'b0;
            r_lives           <= C_LIVES;
            r_score           <= 8'd0;
        end else begin
            // Free-running so the moment the player presses start seeds the game
            r_lfsr          <= {r_lfsr[6:0], w_lfsr_fb};
            r_verdict_valid <= 1'b0;

            if (w_start_game) begin
                r_lives  <= C_LIVES;
                r_score  <= 8'd0;
                r_window <= C_ROUND;
            end

            case (r_state)
                S_ISSUE: begin
                    r_instr     <= w_issue_code;
                    r_instr_not <= r_lfsr[7];
                    r_timer     <= r_window - C_ONE;
                end
                S_WAIT_KEY: begin
                    if (w_key_hit) begin
                        r_verdict_valid   <= 1'b1;
                        r_verdict_correct <= w_key_correct;
                        r_timeout         <= 1'b0;
                        r_timer           <= C_FEEDBACK_LOAD;
                        if (w_key_correct) begin
                            r_score  <= w_score_inc;
                            r_window <= w_window_dec;
                        end else begin
                            r_lives <= w_lives_dec;
                        end
                    end else if (w_expire) begin
                        r_verdict_valid   <= 1'b1;
                        r_verdict_correct <= 1'b0;
                        r_timeout         <= 1'b1;
                        r_timer           <= C_FEEDBACK_LOAD;
                        r_lives           <= w_lives_dec;
                    end else begin
                        r_timer <= r_timer - C_ONE;
                    end
                end
                S_CORRECT, S_WRONG: begin
                    if (!w_timer_zero) begin
                        r_timer <= r_timer - C_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign instr           = r_instr;
    assign instr_not       = r_instr_not;
    assign instr_valid     = (r_state == S_WAIT_KEY);
    assign verdict_valid   = r_verdict_valid;
    assign verdict_correct = r_verdict_correct;
    assign timeout         = r_timeout;
    assign lives           = r_lives;
    assign score           = r_score;
    assign game_over       = (r_state == S_GAME_OVER);

endmodule

// File: tb/tb_round_scheduler.sv
// -----------------------------------------------------------------------------
// tb_round_scheduler
//
// Directed bench for round_scheduler with a short-window configuration.
// Expected verdicts are queued when a key is pressed (or a timeout is awaited)
// and compared by a monitor when verdict_valid fires. Instructions are checked
// against an independent LFSR model; response-window lengths are checked by
// measuring the distance from instr_valid to a timeout verdict.
// -----------------------------------------------------------------------------
module tb_round_scheduler;

    localparam int P_LIVES = 3;
    localparam int P_ROUND = 20;
    localparam int P_MIN   = 8;
    localparam int P_STEP  = 4;
    localparam int P_FB    = 4;
    localparam int P_CW    = 28;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       key_valid = 1'b0;
    logic [2:0] key_class = 3'd0;
    logic [2:0] instr;
    logic       instr_not;
    logic       instr_valid;
    logic       verdict_valid;
    logic       verdict_correct;
    logic       timeout;
    logic [1:0] lives;
    logic [7:0] score;
    logic       game_over;

    always #5 clk = ~clk;

    round_scheduler #(
        .LIVES           (P_LIVES),
        .ROUND_CYCLES    (P_ROUND),
        .MIN_CYCLES      (P_MIN),
        .STEP_CYCLES     (P_STEP),
        .FEEDBACK_CYCLES (P_FB),
        .CW              (P_CW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .key_valid       (key_valid),
        .key_class       (key_class),
        .instr           (instr),
        .instr_not       (instr_not),
        .instr_valid     (instr_valid),
        .verdict_valid   (verdict_valid),
        .verdict_correct (verdict_correct),
        .timeout         (timeout),
        .lives           (lives),
        .score           (score),
        .game_over       (game_over)
    );

    typedef struct packed {
        logic       correct;
        logic       tmo;
        logic [1:0] lives;
        logic [7:0] score;
    } verdict_t;

    verdict_t   exp_q[$];
    int         checks = 0;
    int         failures = 0;
    int         exp_lives;
    int         exp_score;
    int         exp_window;
    logic [2:0] cur_instr;
    logic       cur_not;

    // Independent model of the instruction LFSR (x^8+x^6+x^5+x^4+1)
    logic [7:0] m_lfsr;
    logic [7:0] m_prev;
    always @(posedge clk) begin
        m_prev <= m_lfsr;
        m_lfsr <= reset ? 8'hA5 : {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Verdict monitor: pops the scoreboard on each verdict pulse
    initial begin
        logic     prev_vv;
        verdict_t e;
        prev_vv = 1'b0;
        forever begin
            tick();
            if (prev_vv) begin
                check("verdict_pulse_width", verdict_valid, 0);
            end
            if (verdict_valid && !prev_vv) begin
                check("verdict_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("verdict_correct", verdict_correct, e.correct);
                    check("verdict_timeout", timeout, e.tmo);
                    check("verdict_lives", lives, e.lives);
                    check("verdict_score", score, e.score);
                    $display("verdict: correct=%0d timeout=%0d lives=%0d score=%0d",
                             verdict_correct, timeout, lives, score);
                end
            end
            prev_vv = verdict_valid;
        end
    end

    // Wait for a new round's first WAIT_KEY cycle and check its instruction
    task automatic wait_issue(output int n);
        n = 0;
        while (!instr_valid && n < 200) begin
            tick();
            n++;
        end
        check("issue_seen", instr_valid, 1);
        cur_instr = (m_prev[2:0] >= 3'd6) ? (m_prev[2:0] - 3'd6) : m_prev[2:0];
        cur_not   = m_prev[7];
        check("instr", instr, cur_instr);
        check("instr_not", instr_not, cur_not);
        $display("issue: instr=%0d not=%0d", instr, instr_not);
    endtask

    task automatic wait_verdict(output int n);
        n = 0;
        while (!verdict_valid && n < 200) begin
            tick();
            n++;
        end
        check("verdict_seen", verdict_valid, 1);
    endtask

    function automatic logic [2:0] key_for(input logic want_correct);
        if (cur_not) begin
            return want_correct ? 3'd7 : cur_instr;
        end
        return want_correct ? cur_instr : ((cur_instr == 3'd5) ? 3'd0 : cur_instr + 3'd1);
    endfunction

    // Press key k after 'delay' further cycles of WAIT_KEY and queue the verdict
    task automatic press(input logic [2:0] k, input int delay);
        logic ok;
        repeat (delay) tick();
        ok = cur_not ? (k != cur_instr) : (k == cur_instr);
        if (ok) begin
            if (exp_score < 255) exp_score++;
            if (exp_window >= P_MIN + P_STEP) exp_window -= P_STEP;
            else exp_window = P_MIN;
        end else if (exp_lives > 0) begin
            exp_lives--;
        end
        exp_q.push_back({ok, 1'b0, 2'(exp_lives), 8'(exp_score)});
        key_class = k;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
    endtask

    // Let the round expire and check the measured window length
    task automatic timeout_round(input string tag);
        int n;
        if (exp_lives > 0) exp_lives--;
        exp_q.push_back({1'b0, 1'b1, 2'(exp_lives), 8'(exp_score)});
        wait_verdict(n);
        check(tag, n, exp_window);
    endtask

    task automatic check_reset_outputs();
        check("rst_instr", instr, 0);
        check("rst_instr_not", instr_not, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_verdict_valid", verdict_valid, 0);
        check("rst_verdict_correct", verdict_correct, 0);
        check("rst_timeout", timeout, 0);
        check("rst_lives", lives, P_LIVES);
        check("rst_score", score, 0);
        check("rst_game_over", game_over, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        exp_lives  = P_LIVES;
        exp_score  = 0;
        exp_window = P_ROUND;
        check_reset_outputs();

        // Key in IDLE is ignored
        key_class = 3'd0;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        check("idle_key_ignored", instr_valid, 0);

        // Game 1
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_lives", lives, P_LIVES);
        wait_issue(n);

        timeout_round("window_20");
        wait_issue(n);
        check("feedback_len_wrong", n, P_FB + 1);

        press(key_for(1'b1), 0);
        wait_verdict(n);
        wait_issue(n);
        check("feedback_len_correct", n, P_FB + 1);

        timeout_round("window_16");
        wait_issue(n);

        // Key on the exact expiry cycle is judged as a keypress
        press(key_for(1'b1), exp_window - 1);
        wait_verdict(n);
        check("expiry_key_latency", n, 0);
        wait_issue(n);

        // Answer correctly until a negated round appears, then press OTHER
        for (int r = 0; r < 40 && !cur_not; r++) begin
            press(key_for(1'b1), 1);
            wait_verdict(n);
            wait_issue(n);
        end
        check("negated_round_found", cur_not, 1);
        press(3'd7, 2);
        wait_verdict(n);

        // One more correct at the floor keeps the window at MIN
        wait_issue(n);
        press(key_for(1'b1), 0);
        wait_verdict(n);
        wait_issue(n);
        timeout_round("window_floor_8");

        n = 0;
        while (!game_over && n < 50) begin
            tick();
            n++;
        end
        check("game_over_delay", n, P_FB);
        check("game_over_lives", lives, 0);

        // Keys in GAME_OVER are ignored and verdict outputs hold
        key_class = 3'd7;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (5) tick();
        check("game_over_held", game_over, 1);
        check("game_over_score_held", score, exp_score);
        check("game_over_timeout_held", timeout, 1);

        // Restart from GAME_OVER
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_lives  = P_LIVES;
        exp_score  = 0;
        exp_window = P_ROUND;
        check("restart_lives", lives, P_LIVES);
        check("restart_score", score, 0);
        check("restart_game_over", game_over, 0);
        wait_issue(n);

        // Game 2: pressing the named key on a negated round is wrong
        for (int r = 0; r < 40 && !cur_not; r++) begin
            press(key_for(1'b1), 1);
            wait_verdict(n);
            wait_issue(n);
        end
        check("negated_round_found2", cur_not, 1);
        press(cur_instr, 1);
        wait_verdict(n);
        wait_issue(n);

        // start in WAIT_KEY is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_in_wait", instr_valid, 1);

        // Reset mid-round aborts without a verdict
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_outputs();
        repeat (30) tick();
        check("after_reset_idle", instr_valid, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
